// File: rtl/frame_window_scheduler_pkg.sv
// Shared types and helpers for the frame window scheduler: FSM encoding,
// default geometry and modular slot distance.
package frame_window_scheduler_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RUN  = 2'd3
    } sched_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_WORDS     = 16;
    localparam int DEF_NUM_SLOTS = 8;
    localparam int DEF_WINDOW    = 7;
    localparam int DEF_ADDR_W    = $clog2(DEF_WORDS * DEF_NUM_SLOTS);

    // Distance from slot b forward to slot a around a power-of-2 ring.
    function automatic int unsigned slot_dist(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned num_slots);
        return (a - b) & (num_slots - 1);
    endfunction

endpackage

// File: rtl/frame_window_scheduler_wr_ptr.sv
// Write pointer for the DMEM frame ring: word/slot counters plus the
// frame-complete strobe and the slot index of the last finished frame.
module frame_wr_ptr
    import frame_window_scheduler_pkg::*;
#(
    parameter int WORDS     = DEF_WORDS,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    output logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
    output logic [$clog2(WORDS)-1:0]     wr_word,
    output logic                         frame_complete,
    output logic [$clog2(NUM_SLOTS)-1:0] last_slot
);
    localparam int WORD_W = $clog2(WORDS);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic [WORD_W-1:0] wr_word_q, wr_word_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0] last_slot_q, last_slot_d;

    always_comb begin
        wr_word_d      = wr_word_q;
        wr_slot_d      = wr_slot_q;
        last_slot_d    = last_slot_q;
        frame_complete = 1'b0;
        if (accept) begin
            if (wr_word_q == WORD_W'(WORDS - 1)) begin
                frame_complete = 1'b1;
                wr_word_d      = '0;
                wr_slot_d      = wr_slot_q + SLOT_W'(1);
                last_slot_d    = wr_slot_q;
            end else begin
                wr_word_d = wr_word_q + WORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_word_q   <= '0;
            wr_slot_q   <= '0;
            last_slot_q <= '0;
        end else begin
            wr_word_q   <= wr_word_d;
            wr_slot_q   <= wr_slot_d;
            last_slot_q <= last_slot_d;
        end
    end

    assign wr_slot   = wr_slot_q;
    assign wr_word   = wr_word_q;
    assign last_slot = last_slot_q;

endmodule

// File: rtl/frame_window_scheduler.sv
// Write-side DMEM scheduler: packs feature words into a ring of frame slots,
// starts the classifier on each full window and locks it until done.
module frame_window_scheduler
    import frame_window_scheduler_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WORDS     = DEF_WORDS,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int WINDOW    = DEF_WINDOW,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_waddr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cls_start,
    input  logic              cls_done,
    output logic [ADDR_W-1:0] win_base,
    output logic [7:0]        missed_cnt,
    output logic [1:0]        sched_state
);
    localparam int WORD_W = $clog2(WORDS);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int FD_W   = $clog2(WINDOW + 1);

    logic              accept;
    logic              frame_complete;
    logic              in_window;
    logic [WORD_W-1:0] wr_word;
    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] last_slot;
    logic [SLOT_W-1:0] base_slot;
    logic              miss;

    sched_state_e      state_q, state_d;
    logic [FD_W-1:0]   frames_done_q, frames_done_d;
    logic              pending_q, pending_d;
    logic              lock_q, lock_d;
    logic [SLOT_W-1:0] lock_slot_q, lock_slot_d;
    logic [7:0]        missed_q, missed_d;
    logic              cls_start_q, cls_start_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic              dmem_wen_q, dmem_wen_d;
    logic [ADDR_W-1:0] dmem_waddr_q, dmem_waddr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic              ready_en_q, ready_en_d;

    frame_wr_ptr #(
        .WORDS     (WORDS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_wr_ptr (
        .clk            (clk),
        .rst            (rst),
        .accept         (accept),
        .wr_slot        (wr_slot),
        .wr_word        (wr_word),
        .frame_complete (frame_complete),
        .last_slot      (last_slot)
    );

    // Writer stalls only when it would enter a slot of the locked window.
    assign in_window = slot_dist(32'(wr_slot), 32'(lock_slot_q), NUM_SLOTS) < WINDOW;
    assign in_ready  = ready_en_q && !(lock_q && in_window);
    assign accept    = in_valid && in_ready;
    assign base_slot = last_slot - SLOT_W'(WINDOW - 1);

    always_comb begin
        ready_en_d   = 1'b1;
        dmem_wen_d   = accept;
        dmem_waddr_d = dmem_waddr_q;
        dmem_wdata_d = dmem_wdata_q;
        if (accept) begin
            dmem_waddr_d = {wr_slot, wr_word};
            dmem_wdata_d = in_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        frames_done_d = frames_done_q;
        pending_d     = pending_q;
        lock_d        = lock_q;
        lock_slot_d   = lock_slot_q;
        missed_d      = missed_q;
        cls_start_d   = 1'b0;
        win_base_d    = win_base_q;
        miss          = 1'b0;

        if (frame_complete && frames_done_q != FD_W'(WINDOW)) begin
            frames_done_d = frames_done_q + FD_W'(1);
        end

        unique case (state_q)
            FILL: begin
                if (frame_complete && frames_done_q == FD_W'(WINDOW - 1)) begin
                    state_d = WAIT;
                end
            end
            IDLE: begin
                if (frame_complete) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A fresh frame slides the window and defers the start a cycle.
                if (frame_complete) begin
                    miss = 1'b1;
                end else begin
                    cls_start_d = 1'b1;
                    win_base_d  = {base_slot, {WORD_W{1'b0}}};
                    lock_slot_d = base_slot;
                    lock_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (frame_complete) begin
                    if (!pending_q) begin
                        pending_d = 1'b1;
                    end else begin
                        miss = 1'b1;
                    end
                end
                if (cls_done) begin
                    lock_d    = 1'b0;
                    pending_d = 1'b0;
                    state_d   = (pending_q || frame_complete) ? WAIT : IDLE;
                end
            end
        endcase

        if (miss && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FILL;
            frames_done_q <= '0;
            pending_q     <= 1'b0;
            lock_q        <= 1'b0;
            lock_slot_q   <= '0;
            missed_q      <= '0;
            cls_start_q   <= 1'b0;
            win_base_q    <= '0;
            dmem_wen_q    <= 1'b0;
            dmem_waddr_q  <= '0;
            dmem_wdata_q  <= '0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frames_done_q <= frames_done_d;
            pending_q     <= pending_d;
            lock_q        <= lock_d;
            lock_slot_q   <= lock_slot_d;
            missed_q      <= missed_d;
            cls_start_q   <= cls_start_d;
            win_base_q    <= win_base_d;
            dmem_wen_q    <= dmem_wen_d;
            dmem_waddr_q  <= dmem_waddr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            ready_en_q    <= ready_en_d;
        end
    end

    assign dmem_wen    = dmem_wen_q;
    assign dmem_waddr  = dmem_waddr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign cls_start   = cls_start_q;
    assign win_base    = win_base_q;
    assign missed_cnt  = missed_q;
    assign sched_state = state_q;

endmodule
